// File: rtl/fix2flt_pkg.sv
// Shared types and default format constants for the fixed-to-float converter.
// Default format: Q8.8 input converted to an IEEE half-precision output.
package fix2flt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic {
        RND_RNE   = 1'b0,
        RND_TRUNC = 1'b1
    } rnd_mode_e;

    localparam int DEF_IN_W   = 16;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_EXP_W  = 5;
    localparam int DEF_MAN_W  = 10;
    localparam int DEF_BIAS   = 15;

    // Exponent counter width: the count starts at IN_W-1-FRAC_W+BIAS and can
    // walk below zero during normalisation, so it carries a sign bit plus one
    // bit of headroom for the rounding carry.
    function automatic int exp_cnt_w(input int in_w, input int frac_w, input int exp_w);
        return $clog2(in_w + frac_w + (1 << exp_w)) + 2;
    endfunction

endpackage

// File: rtl/fix2flt_rnd.sv
// Combinational mantissa extraction and rounding from the normalised fraction
// bits (the bits below the hidden one).
module fix2flt_rnd #(
    parameter int IN_W  = 16,
    parameter int MAN_W = 10
) (
    input  logic [IN_W-2:0]  i_frac,
    input  logic             i_trunc,
    output logic [MAN_W-1:0] o_man,
    output logic             o_carry
);

    // Zero padding below the fraction keeps all slices in range even when
    // the fraction is narrower than the mantissa.
    localparam int EXT_W = IN_W + MAN_W;

    logic [EXT_W-1:0] w_ext;
    logic [MAN_W-1:0] w_man;
    logic             w_guard;
    logic             w_sticky;
    logic             w_inc;
    logic [MAN_W:0]   w_sum;

    assign w_ext    = {i_frac, {(MAN_W+1){1'b0}}};
    assign w_man    = w_ext[EXT_W-1 -: MAN_W];
    assign w_guard  = w_ext[EXT_W-1-MAN_W];
    assign w_sticky = |w_ext[EXT_W-2-MAN_W:0];
    assign w_inc    = ~i_trunc & w_guard & (w_sticky | w_man[0]);
    assign w_sum    = {1'b0, w_man} + {{MAN_W{1'b0}}, w_inc};
    assign o_man    = w_sum[MAN_W-1:0];
    assign o_carry  = w_sum[MAN_W];

endmodule

// File: rtl/fix2flt_conv.sv
// Multi-cycle fixed-point to floating-point converter: one leading zero is
// normalised per cycle, then the result is rounded and held until the next start.
module fix2flt_conv
    import fix2flt_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MAN_W  = DEF_MAN_W,
    parameter int BIAS   = DEF_BIAS,
    parameter int SIGNED = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [IN_W-1:0]        i_fix_in,
    input  logic                   i_rnd_mode,
    output logic [EXP_W+MAN_W:0]   o_flt_out,
    output logic                   o_done,
    output logic                   o_busy,
    output logic                   o_ovf,
    output logic                   o_unf
);

    localparam int XW = exp_cnt_w(IN_W, FRAC_W, EXP_W);
    localparam logic signed [XW-1:0] EXP_INIT = XW'(IN_W - 1 - FRAC_W + BIAS);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);

    state_e                 r_state;
    logic [IN_W-1:0]        r_fix;
    logic [IN_W-1:0]        r_acc;
    logic                   r_trunc;
    logic                   r_sign;
    logic signed [XW-1:0]   r_exp;

    logic                   w_neg;
    logic [IN_W-1:0]        w_abs;
    logic [MAN_W-1:0]       w_man;
    logic                   w_carry;
    logic signed [XW-1:0]   w_exp_rnd;

    // Two's-complement magnitude; the most-negative value maps onto 1 << (IN_W-1).
    assign w_neg     = (SIGNED != 0) && r_fix[IN_W-1];
    assign w_abs     = w_neg ? (~r_fix + IN_W'(1)) : r_fix;
    assign w_exp_rnd = r_exp + $signed({{(XW-1){1'b0}}, w_carry});

    fix2flt_rnd #(
        .IN_W  (IN_W),
        .MAN_W (MAN_W)
    ) u_rnd (
        .i_frac  (r_acc[IN_W-2:0]),
        .i_trunc (r_trunc),
        .o_man   (w_man),
        .o_carry (w_carry)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_fix     <= '0;
            r_acc     <= '0;
            r_trunc   <= 1'b0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            o_flt_out <= '0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
            o_ovf     <= 1'b0;
            o_unf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_fix   <= i_fix_in;
                        r_trunc <= i_rnd_mode;
                        r_state <= ST_LOAD;
                        o_done  <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_sign <= w_neg;
                    r_acc  <= w_abs;
                    r_exp  <= EXP_INIT;
                    if (w_abs == '0) begin
                        r_state   <= ST_DONE;
                        o_flt_out <= '0;
                        o_ovf     <= 1'b0;
                        o_unf     <= 1'b0;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                    end else if (w_abs[IN_W-1]) begin
                        r_state <= ST_ROUND;
                    end else begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    // Look ahead one bit so the shift that sets the MSB also
                    // hands off to ROUND without an extra idle check cycle.
                    r_acc <= r_acc << 1;
                    r_exp <= r_exp - EXP_ONE;
                    if (r_acc[IN_W-2]) begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_state <= ST_DONE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                    if (w_exp_rnd >= EXP_MAX) begin
                        o_flt_out <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        o_ovf     <= 1'b1;
                        o_unf     <= 1'b0;
                    end else if (w_exp_rnd <= EXP_ZERO) begin
                        o_flt_out <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
                        o_ovf     <= 1'b0;
                        o_unf     <= 1'b1;
                    end else begin
                        o_flt_out <= {r_sign, w_exp_rnd[EXP_W-1:0], w_man};
                        o_ovf     <= 1'b0;
                        o_unf     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
